// File: rtl/pipe_delay_tracker.sv
// Elastic DEPTH-stage delay line for multi-cycle execute units: payload plus
// register-write tags, per-stage/global flush, bubble collapsing, hazard lookups.
module pipe_delay_tracker #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 3,
  parameter int RD_W    = 5,
  parameter int N_QUERY = 2,
  localparam int CW     = $clog2(DEPTH + 1),
  localparam int SW     = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [WIDTH-1:0]        data_i,
  input  logic [RD_W-1:0]         rd_i,
  input  logic                    reg_write_i,
  input  logic                    fp_reg_write_i,
  input  logic [DEPTH-1:0]        flush_i,
  input  logic                    flush_all_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [WIDTH-1:0]        data_o,
  output logic [RD_W-1:0]         rd_o,
  output logic                    reg_write_o,
  output logic                    fp_reg_write_o,
  output logic [DEPTH-1:0]        stage_valid_o,
  output logic [CW-1:0]           count_o,
  input  logic [N_QUERY*RD_W-1:0] qry_rs_i,
  input  logic [N_QUERY-1:0]      qry_fp_i,
  output logic [N_QUERY-1:0]      qry_hit_o,
  output logic [N_QUERY*SW-1:0]   qry_stage_o
);

  logic [DEPTH-1:0] v_q, rw_q, fw_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [RD_W-1:0]  rd_q   [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_nxt;

  logic [DEPTH-1:0] ev, mv, ld, nv;
  logic             go;
  logic             accept;

  // A stage may advance when every stage ahead of it is either a hole or
  // itself advancing; "go" carries that condition back from the output.
  always_comb begin
    ev = v_q & ~flush_i & {DEPTH{~flush_all_i}};
    mv = '0;
    go = ready_i;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      mv[k] = ev[k] & go;
      go    = go | ~ev[k];
    end
    ready_o = ~flush_all_i & (~ev[0] | mv[0]);
    accept  = valid_i & ready_o;
    ld      = {mv[DEPTH-2:0], accept};
    nv      = ld | (ev & ~mv);
    cnt_nxt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cnt_nxt = cnt_nxt + CW'(nv[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v_q   <= '0;
      rw_q  <= '0;
      fw_q  <= '0;
      cnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
        rd_q[k]   <= '0;
      end
    end else begin
      v_q   <= nv;
      cnt_q <= cnt_nxt;
      if (ld[0]) begin
        data_q[0] <= data_i;
        rd_q[0]   <= rd_i;
        rw_q[0]   <= reg_write_i;
        fw_q[0]   <= fp_reg_write_i;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (ld[k]) begin
          data_q[k] <= data_q[k-1];
          rd_q[k]   <= rd_q[k-1];
          rw_q[k]   <= rw_q[k-1];
          fw_q[k]   <= fw_q[k-1];
        end
      end
    end
  end

  // Scan oldest to youngest so the lowest matching stage wins.
  always_comb begin
    qry_hit_o   = '0;
    qry_stage_o = '0;
    for (int j = 0; j < N_QUERY; j++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (ev[k] && rd_q[k] == qry_rs_i[j*RD_W +: RD_W] &&
            (qry_fp_i[j] ? fw_q[k] : (rw_q[k] && rd_q[k] != '0))) begin
          qry_hit_o[j]             = 1'b1;
          qry_stage_o[j*SW +: SW]  = SW'(k);
        end
      end
    end
  end

  assign valid_o        = ev[DEPTH-1];
  assign data_o         = data_q[DEPTH-1];
  assign rd_o           = rd_q[DEPTH-1];
  assign reg_write_o    = rw_q[DEPTH-1];
  assign fp_reg_write_o = fw_q[DEPTH-1];
  assign stage_valid_o  = ev;
  assign count_o        = cnt_q;

endmodule

// File: tb/tb_pipe_delay_tracker.sv
// Directed and random stimulus for pipe_delay_tracker, checked each cycle
// against an age-ordered entry list that moves entries by position.
module tb_pipe_delay_tracker;
  localparam int WIDTH = 32, DEPTH = 3, RD_W = 5, N_QUERY = 2;
  localparam int CW = $clog2(DEPTH + 1), SW = $clog2(DEPTH);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    reset_n, valid_i, ready_o, reg_write_i, fp_reg_write_i;
  logic [WIDTH-1:0]        data_i, data_o;
  logic [RD_W-1:0]         rd_i, rd_o;
  logic [DEPTH-1:0]        flush_i, stage_valid_o;
  logic                    flush_all_i, valid_o, ready_i, reg_write_o, fp_reg_write_o;
  logic [CW-1:0]           count_o;
  logic [N_QUERY*RD_W-1:0] qry_rs_i;
  logic [N_QUERY-1:0]      qry_fp_i, qry_hit_o;
  logic [N_QUERY*SW-1:0]   qry_stage_o;

  pipe_delay_tracker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_W(RD_W), .N_QUERY(N_QUERY)) dut (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .rd_i(rd_i), .reg_write_i(reg_write_i),
    .fp_reg_write_i(fp_reg_write_i), .flush_i(flush_i), .flush_all_i(flush_all_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .rd_o(rd_o),
    .reg_write_o(reg_write_o), .fp_reg_write_o(fp_reg_write_o),
    .stage_valid_o(stage_valid_o), .count_o(count_o), .qry_rs_i(qry_rs_i),
    .qry_fp_i(qry_fp_i), .qry_hit_o(qry_hit_o), .qry_stage_o(qry_stage_o)
  );

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [RD_W-1:0]  rd;
    logic             rw;
    logic             fw;
    int               pos;
  } ent_t;

  ent_t q[$];           // oldest first
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic [RD_W-1:0] r,
                       input logic rw, input logic fw);
    valid_i = v; data_i = d; rd_i = r; reg_write_i = rw; fp_reg_write_i = fw;
  endtask

  // One clock: check all outputs against the model, then apply the edge.
  task automatic step();
    ent_t live[$];
    ent_t nq[$];
    ent_t e;
    logic [DEPTH-1:0] want_sv;
    logic head, in_rdy;
    #1;
    if (!reset_n) begin
      @(posedge clk);
      q.delete();
      #1;
      return;
    end
    foreach (q[i]) if (!(flush_all_i || flush_i[q[i].pos])) live.push_back(q[i]);
    want_sv = '0;
    foreach (live[i]) want_sv[live[i].pos] = 1'b1;
    head = (live.size() > 0) && (live[0].pos == DEPTH - 1);
    check("valid_o", valid_o, head);
    if (head) begin
      check("data_o", data_o, live[0].data);
      check("rd_o", rd_o, live[0].rd);
      check("reg_write_o", reg_write_o, live[0].rw);
      check("fp_reg_write_o", fp_reg_write_o, live[0].fw);
    end
    check("stage_valid_o", stage_valid_o, want_sv);
    check("count_o", count_o, q.size());
    for (int j = 0; j < N_QUERY; j++) begin
      logic [RD_W-1:0] rs;
      logic h;
      int s;
      rs = qry_rs_i[j*RD_W +: RD_W];
      h = 1'b0;
      s = 0;
      foreach (live[i])
        if (live[i].rd == rs && (qry_fp_i[j] ? live[i].fw : (live[i].rw && live[i].rd != 0))) begin
          if (!h || live[i].pos < s) s = live[i].pos;
          h = 1'b1;
        end
      check($sformatf("qry_hit[%0d]", j), qry_hit_o[j], h);
      check($sformatf("qry_stage[%0d]", j), qry_stage_o[j*SW +: SW], s);
    end
    // Oldest first: leave at the end if the consumer takes it, else step
    // forward whenever the position ahead is free after older entries moved.
    foreach (live[i]) begin
      e = live[i];
      if (e.pos == DEPTH - 1) begin
        if (!ready_i) nq.push_back(e);
      end else begin
        if (nq.size() == 0 || nq[nq.size()-1].pos > e.pos + 1) e.pos++;
        nq.push_back(e);
      end
    end
    in_rdy = !flush_all_i && (nq.size() == 0 || nq[nq.size()-1].pos > 0);
    check("ready_o", ready_o, in_rdy);
    if (valid_i && in_rdy) begin
      e.data = data_i; e.rd = rd_i; e.rw = reg_write_i; e.fw = fp_reg_write_i; e.pos = 0;
      nq.push_back(e);
    end
    @(posedge clk);
    q = nq;
    #1;
  endtask

  initial begin
    int lat;
    reset_n = 1'b0; ready_i = 1'b1; flush_i = '0; flush_all_i = 1'b0;
    qry_rs_i = '0; qry_fp_i = '0;
    drive(0, 0, 0, 0, 0);
    step(); step();
    reset_n = 1'b1;
    check("reset_ready_o", ready_o, 1'b1);
    check("reset_data_o", data_o, 0);
    step();

    // Single entry latency
    drive(1, 32'hA5, 7, 1, 0);
    step();
    drive(0, 0, 0, 0, 0);
    lat = 1;
    while (!valid_o && lat < 10) begin step(); lat++; end
    check("latency", lat, DEPTH);
    check("lat_data_o", data_o, 32'hA5);
    check("lat_rd_o", rd_o, 7);
    step(); step();

    // Back-to-back stream into a stalled consumer, then drain
    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin drive(1, 32'h100 + i, 5'(i + 1), 1, 0); step(); end
    drive(0, 0, 0, 0, 0);
    check("full_count", count_o, 3);
    check("full_ready", ready_o, 1'b0);
    ready_i = 1'b1;
    #1 check("drain_ready", ready_o, 1'b1);
    repeat (4) step();

    // Middle-stage kill while full and stalled
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin drive(1, 32'h200 + i, 5'(i + 1), 1, 0); step(); end
    drive(0, 0, 0, 0, 0);
    flush_i = 3'b010;
    step();
    flush_i = '0;
    check("flush_mid_count", count_o, 2);
    ready_i = 1'b1;
    repeat (4) step();

    // Global flush with input valid
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin drive(1, 32'h300 + i, 5'(i + 1), 0, 1); step(); end
    flush_all_i = 1'b1;
    #1 check("flush_all_ready", ready_o, 1'b0);
    step();
    flush_all_i = 1'b0;
    drive(0, 0, 0, 0, 0);
    check("flush_all_count", count_o, 0);
    ready_i = 1'b1;
    repeat (3) begin step(); check("flush_all_no_out", valid_o, 1'b0); end

    // Hazard lookups
    ready_i = 1'b0;
    drive(1, 32'h1, 5, 0, 1); step();
    drive(1, 32'h2, 3, 1, 0); step();
    drive(1, 32'h3, 5, 0, 1); step();
    drive(0, 0, 0, 0, 0);
    qry_rs_i = {5'd3, 5'd5}; qry_fp_i = 2'b01;
    #1;
    check("q_fp_hit", qry_hit_o[0], 1'b1);
    check("q_fp_stage", qry_stage_o[0 +: SW], 0);
    check("q_int_rd3_stage", qry_stage_o[SW +: SW], 1);
    step();
    qry_fp_i = 2'b00;
    #1 check("q_int_miss", qry_hit_o[0], 1'b0);
    step();
    flush_all_i = 1'b1; step(); flush_all_i = 1'b0;
    drive(1, 32'h4, 0, 1, 0); step();
    drive(0, 0, 0, 0, 0);
    qry_rs_i = '0; qry_fp_i = '0;
    #1 check("q_rd0_miss", qry_hit_o, 2'b00);
    step();

    // Reset with traffic in flight
    for (int i = 0; i < 2; i++) begin drive(1, 32'h500 + i, 5'(i + 1), 1, 0); step(); end
    drive(0, 0, 0, 0, 0);
    reset_n = 1'b0; step(); reset_n = 1'b1;
    ready_i = 1'b1;
    check("rst_valid_o", valid_o, 1'b0);
    check("rst_count", count_o, 0);
    check("rst_ready", ready_o, 1'b1);
    repeat (4) step();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, 5'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom));
      ready_i     = $urandom_range(0, 9) < 6;
      flush_i     = ($urandom_range(0, 7) == 0) ? DEPTH'($urandom) : '0;
      flush_all_i = $urandom_range(0, 29) == 0;
      qry_rs_i    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      qry_fp_i    = 2'($urandom);
      reset_n     = $urandom_range(0, 99) != 0;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_delay_tracker.md
Name: pipe_delay_tracker

Overview:
- Parametrised elastic delay line for multi-cycle execute units (FP add/mul, integer mul/div).
- Carries each instruction's payload and destination-write tags through DEPTH stages.
- Adds per-stage valid bits, valid/ready backpressure with bubble collapsing, per-stage and global flush, and occupancy count.
- Exposes N_QUERY RAW/WAW lookup ports so the hazard unit sees in-flight writers directly, instead of decoding raw per-stage rd and write-enable vectors.

Parameters:
- WIDTH, 32, payload bits per entry (excluding tags).
- DEPTH, 3, number of pipeline stages; legal range 2..16.
- RD_W, 5, destination register address width.
- N_QUERY, 2, number of hazard lookup ports.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- valid_i  in  1  input entry valid.
- ready_o  out  1  stage 0 can accept this cycle.
- data_i  in  WIDTH  input payload.
- rd_i  in  RD_W  destination register.
- reg_write_i  in  1  entry writes the integer register file.
- fp_reg_write_i  in  1  entry writes the FP register file.
- flush_i  in  DEPTH  per-stage kill; bit k kills the entry in stage k.
- flush_all_i  in  1  kill all stages and block input.
- valid_o  out  1  output entry valid.
- ready_i  in  1  consumer accepts the output.
- data_o  out  WIDTH  output payload.
- rd_o  out  RD_W  output destination register.
- reg_write_o  out  1  output integer-write tag.
- fp_reg_write_o  out  1  output FP-write tag.
- stage_valid_o  out  DEPTH  per-stage valid, after flush masking.
- count_o  out  clog2(DEPTH+1)  number of valid entries.
- qry_rs_i  in  N_QUERY*RD_W  lookup addresses.
- qry_fp_i  in  N_QUERY  1 = query the FP file, 0 = query the integer file.
- qry_hit_o  out  N_QUERY  an in-flight writer matches.
- qry_stage_o  out  N_QUERY*clog2(DEPTH)  stage index of the youngest match.

Behaviour:
- Reset: when reset_n=0 at a rising edge:
  - All stage valids clear; payload and tag registers clear to 0.
  - valid_o=0, count_o=0, qry_hit_o=0, qry_stage_o=0.
  - ready_o=1 from the first cycle after reset.
  - Reset overrides every other input, including mid-stream traffic; all in-flight entries are lost.
- Effective valid: ev[k] = v[k] & ~flush_i[k] & ~flush_all_i. All outputs and lookups use ev, never raw v.
- Advance rule, combinational, evaluated from the last stage backwards:
  - mv[DEPTH-1] = ev[DEPTH-1] & ready_i.
  - For k<DEPTH-1: mv[k] = ev[k] & (~ev[k+1] | mv[k+1]).
  - A killed or empty stage counts as a hole; the stage behind it may move into it in the same cycle (bubble collapsing).
- Stage k is loaded when mv[k-1]=1 (stage 0 is loaded when the input handshake fires); otherwise it holds. Its valid becomes 0 when it moves out with nothing moving in, or when it is killed.
- Input side:
  - ready_o = ~flush_all_i & (~ev[0] | mv[0]).
  - An entry is accepted when valid_i & ready_o.
- Output side:
  - valid_o = ev[DEPTH-1]; data/tag outputs come directly from the last-stage registers.
  - A killed last stage never completes a handshake, even if ready_i=1.
- Latency: an entry accepted at cycle t presents valid_o at t+DEPTH when no stall occurs. Throughput is 1 entry per cycle.
- flush_all_i: every stage valid is 0 at the next edge, the input is blocked, count_o reads 0 the next cycle. Payload registers are don't-care.
- Simultaneous flush_i[k] and an incoming move into stage k: the incoming entry is kept; only the old occupant dies.
- count_o is registered: next = popcount of next-cycle stage valids.
- Lookup j, combinational:
  - Match in stage k when ev[k] & (rd[k]==qry_rs_j) & (qry_fp_j ? fp_reg_write[k] : (reg_write[k] & rd[k]!=0)).
  - qry_hit_o[j] = OR of matches across stages.
  - qry_stage_o[j] = lowest matching k (youngest entry, which decides WAW order); 0 when there is no hit.
- Full: all ev=1 and ready_i=0 gives ready_o=0 and every stage holds.
- Empty: valid_o=0; ready_i is ignored.

Test Plan:
- DEPTH=3, ready_i=1, inject a single entry data_i=0xA5, rd_i=7 at cycle 10 -> valid_o=1, data_o=0xA5, rd_o=7 at cycle 13 only.
- Stream 5 back-to-back entries with ready_i=0 -> after 3 accepts ready_o=0, count_o=3. Then ready_i=1 -> outputs appear in order, one per cycle, and ready_o=1 in the same cycle.
- Pipeline full and stalled, pulse flush_i=3'b010 for one cycle -> middle entry never reaches the output. Stage 0 moves into stage 1 that same cycle; count_o goes from 3 to 2.
- Three entries in flight with ready_i=0, flush_all_i=1 while valid_i=1 -> ready_o=0 that cycle, count_o=0 the next cycle, no valid_o afterwards.
- Stage 0 rd=5 FP-write, stage 2 rd=5 FP-write, query rs=5 qry_fp=1 -> hit=1, stage=0. Same query with qry_fp=0 -> hit=0. Integer entry with rd=0 queried with rs=0 -> hit=0.
- Drop reset_n for one cycle with 3 entries in flight -> next cycle valid_o=0, count_o=0, ready_o=1, and no stale entry is ever output.
